// File: rtl/bus_initiator.sv
`default_nettype none
// ============================================================================
// Module  : bus_initiator
// Purpose : Root bus master. Turns a valid/ready command stream into one bus
//           transaction at a time (posted write strobe, or read strobe plus
//           wait for rd_ack) and returns a one-cycle response pulse. A read
//           that gets no rd_ack within TIMEOUT cycles completes with rsp_err.
// Ports   : bus_clk, bus_reset_l     - clock / async active-low reset
//           bus_in  (out)            - bundle to the tree: rd_req, wr_req,
//                                      wr_data, addr, be, clk, reset_l
//           bus_out (in)             - returned bundle: rd_data, rd_ack
//           req_valid/req_ready      - command handshake
//           req_wr/addr/wdata/be     - command fields
//           rsp_valid/rdata/err      - response pulse, data, timeout flag
// Revision: 1.0 - initial release
// ============================================================================
module bus_initiator #(
  parameter int TIMEOUT         = 255,
  // Shared bus layout; these mirror the tree-wide bus parameters and are not
  // meant to be overridden per instance.
  parameter int BUS_ADDR_WIDTH  = 16,
  parameter int BUS_DATA_WIDTH  = 32,
  parameter int BUS_CLK_IDX     = 0,
  parameter int BUS_RESET_L_IDX = 1,
  parameter int BUS_RD_REQ_IDX  = 2,
  parameter int BUS_WR_REQ_IDX  = 3,
  parameter int BUS_BE_LSB      = 4,
  parameter int BUS_ADDR_LSB    = 8,
  parameter int BUS_WDATA_LSB   = 24,
  parameter int BUS_IN_WIDTH    = 56,
  parameter int BUS_RDATA_LSB   = 0,
  parameter int BUS_RD_ACK_IDX  = 32,
  parameter int BUS_OUT_WIDTH   = 33
) (
  input  logic                      bus_clk,
  input  logic                      bus_reset_l,
  output logic [BUS_IN_WIDTH-1:0]   bus_in,
  input  logic [BUS_OUT_WIDTH-1:0]  bus_out,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr,
  input  logic [BUS_ADDR_WIDTH-1:0] req_addr,
  input  logic [BUS_DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]                req_be,
  output logic                      rsp_valid,
  output logic [BUS_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err
);

  localparam int         CNT_W    = 16;
  // Counter value during the last allowed RD cycle (C1 holds 0).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RSP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [BUS_ADDR_WIDTH-1:0] addr_q;
  logic [BUS_DATA_WIDTH-1:0] wdata_q;
  logic [3:0]                be_q;
  logic                      rd_req_q;
  logic                      wr_req_q;
  logic [CNT_W-1:0]          cnt;

  logic                      rd_ack;
  logic [BUS_DATA_WIDTH-1:0] rd_data;
  logic                      accept;
  logic                      rd_expired;

  assign rd_ack     = bus_out[BUS_RD_ACK_IDX];
  assign rd_data    = bus_out[BUS_RDATA_LSB +: BUS_DATA_WIDTH];
  assign accept     = (state == IDLE) && req_valid;
  assign rd_expired = (cnt == CNT_LAST);
  assign req_ready  = (state == IDLE);

  // State register
  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_wr ? WR : RD;
      WR:      state_nxt = RSP;
      // rd_ack in the final allowed cycle still counts as success
      RD:      if (rd_ack || rd_expired) state_nxt = RSP;
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus fields, strobes, counter and response registers
  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      // Strobes and the response are single-cycle pulses by default
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      rsp_valid <= 1'b0;

      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        be_q     <= req_be;
        wr_req_q <= req_wr;
        rd_req_q <= !req_wr;
        cnt      <= '0;
      end

      if (state == WR) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end

      if (state == RD) begin
        cnt <= cnt + CNT_W'(1);
        if (rd_ack) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= rd_data;
        end else if (rd_expired) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
    end
  end

  // Outgoing bundle; clk and reset_l are straight combinational copies
  always_comb begin
    bus_in                                     = '0;
    bus_in[BUS_CLK_IDX]                        = bus_clk;
    bus_in[BUS_RESET_L_IDX]                    = bus_reset_l;
    bus_in[BUS_RD_REQ_IDX]                     = rd_req_q;
    bus_in[BUS_WR_REQ_IDX]                     = wr_req_q;
    bus_in[BUS_BE_LSB +: 4]                    = be_q;
    bus_in[BUS_ADDR_LSB +: BUS_ADDR_WIDTH]     = addr_q;
    bus_in[BUS_WDATA_LSB +: BUS_DATA_WIDTH]    = wdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_initiator
// Purpose : Self-checking bench for bus_initiator (TIMEOUT = 8). Expected
//           responses are queued when commands are issued and compared in
//           order as response pulses appear.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_initiator;

  localparam int TO = 8;

  logic        clk;
  logic        rst_n;
  logic [55:0] bus_in;
  logic [32:0] bus_out;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        ack;
  logic [31:0] ack_data;
  assign bus_out = {ack, ack_data};

  // Bundle fields as seen by a target
  logic        f_clk, f_rstl, f_rd, f_wr;
  logic [3:0]  f_be;
  logic [15:0] f_addr;
  logic [31:0] f_wdata;
  assign f_clk   = bus_in[0];
  assign f_rstl  = bus_in[1];
  assign f_rd    = bus_in[2];
  assign f_wr    = bus_in[3];
  assign f_be    = bus_in[7:4];
  assign f_addr  = bus_in[23:8];
  assign f_wdata = bus_in[55:24];

  bus_initiator #(.TIMEOUT(TO)) dut (
    .bus_clk     (clk),
    .bus_reset_l (rst_n),
    .bus_in      (bus_in),
    .bus_out     (bus_out),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_be      (req_be),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int pulses = 0;
  logic [32:0] exp_q[$];   // {err, rdata}
  logic [32:0] mon_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Response scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e[31:0]));
        check("rsp_err", 64'(rsp_err), 64'(mon_e[32]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a write from an IDLE cycle and follow it through C1..C3
  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_be = be;
    exp_q.push_back({1'b0, 32'h0});
    step();                               // C1
    req_valid = 1'b0;
    check("wr_strobe_c1", 64'(f_wr), 64'd1);
    check("wr_no_rd_c1", 64'(f_rd), 64'd0);
    check("wr_addr", 64'(f_addr), 64'(a));
    check("wr_wdata", 64'(f_wdata), 64'(d));
    check("wr_be", 64'(f_be), 64'(be));
    check("wr_busy_c1", 64'(req_ready), 64'd0);
    step();                               // C2
    check("wr_strobe_c2", 64'(f_wr), 64'd0);
    check("wr_rsp_c2", 64'(rsp_valid), 64'd1);
    step();                               // C3
    check("wr_rsp_c3", 64'(rsp_valid), 64'd0);
    check("wr_ready_c3", 64'(req_ready), 64'd1);
  endtask

  // Issue a read; ack in cycle k (0 = never). Ends in the IDLE cycle after RSP.
  task automatic do_read(input logic [15:0] a, input int k, input logic [31:0] d);
    int  c;
    bit  got;
    bit  err;
    int  exp_c;
    err   = !(k >= 1 && k <= TO);
    exp_c = err ? TO + 1 : k + 1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_wdata = $urandom; req_be = 4'h3;
    exp_q.push_back({err, err ? 32'h0 : d});
    step();                               // C1
    req_valid = 1'b0;
    check("rd_addr", 64'(f_addr), 64'(a));
    check("rd_be", 64'(f_be), 64'h3);
    check("rd_no_wr", 64'(f_wr), 64'd0);
    c = 1;
    got = 1'b0;
    while (!got && c <= 40) begin
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        ack      = (c == k);
        ack_data = (c == k) ? d : 32'hFFFF_0000;
        check("rd_strobe", 64'(f_rd), 64'(c == 1));
        step();
        c++;
      end
    end
    ack = 1'b0;
    check("rd_rsp_cycle", got ? 64'(c) : 64'd0, 64'(exp_c));
    step();
    check("rd_ready_after", 64'(req_ready), 64'd1);
  endtask

  // write, read, write with req_valid held high; target acks one cycle after rd_req
  task automatic do_b2b();
    logic        wr_f[3]  = '{1'b1, 1'b0, 1'b1};
    logic [15:0] ad[3]    = '{16'h0200, 16'h0204, 16'h0208};
    logic [31:0] wd[3]    = '{32'h1111_2222, 32'h0, 32'h3333_4444};
    int          acc_t[$];
    int          idx;
    int          p0;
    logic        prev_rd;
    logic        acc;
    p0 = pulses;
    idx = 0;
    prev_rd = 1'b0;
    req_valid = 1'b1; req_wr = wr_f[0]; req_addr = ad[0]; req_wdata = wd[0]; req_be = 4'hF;
    for (int t = 1; t <= 20; t++) begin
      acc      = req_valid && req_ready;
      ack      = prev_rd;
      ack_data = 32'h0BAD_BEEF;
      prev_rd  = f_rd;
      check("b2b_no_overlap", 64'(f_rd & f_wr), 64'd0);
      step();
      if (acc) begin
        acc_t.push_back(t);
        exp_q.push_back({1'b0, wr_f[idx] ? 32'h0 : 32'h0BAD_BEEF});
        idx++;
        if (idx < 3) begin
          req_wr = wr_f[idx]; req_addr = ad[idx]; req_wdata = wd[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    ack = 1'b0;
    check("b2b_accepts", 64'(acc_t.size()), 64'd3);
    if (acc_t.size() == 3) begin
      check("b2b_gap_wr", 64'(acc_t[1] - acc_t[0]), 64'd3);
      check("b2b_gap_rd", 64'(acc_t[2] - acc_t[1]), 64'd4);
    end
    check("b2b_pulses", 64'(pulses - p0), 64'd3);
  endtask

  initial begin
    rst_n = 1'b0; ack = 1'b0; ack_data = '0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    step();
    step();
    // Reset state
    check("rst_rd_req", 64'(f_rd), 64'd0);
    check("rst_wr_req", 64'(f_wr), 64'd0);
    check("rst_addr", 64'(f_addr), 64'd0);
    check("rst_wdata", 64'(f_wdata), 64'd0);
    check("rst_be", 64'(f_be), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rstl_fwd", 64'(f_rstl), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_ready", 64'(req_ready), 64'd1);
    check("clk_fwd", 64'(f_clk), 64'(clk));
    check("rstl_fwd", 64'(f_rstl), 64'd1);

    do_write(16'h0104, 32'hA5A5_0001, 4'hF);
    do_read(16'h0108, 2, 32'h1234_5678);

    // Timeout, then a late ack in C12 must be ignored
    do_read(16'h0300, 0, 32'h0);          // ends in C10
    step();                               // C11
    step();                               // C12
    ack = 1'b1; ack_data = 32'hDEAD_DEAD;
    step();                               // C13
    ack = 1'b0;
    check("late_ack_no_rsp", 64'(rsp_valid), 64'd0);
    check("late_ack_ready", 64'(req_ready), 64'd1);
    do_read(16'h0304, 2, 32'h5555_AAAA);

    do_read(16'h0400, TO, 32'hCAFE_F00D);  // ack in the final allowed cycle
    do_write(16'h0500, 32'h0000_00FF, 4'h1);

    do_b2b();
    step();

    // Reset in C3 of a pending read: no response, resume in IDLE
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0600; req_be = 4'hF;
    step();                               // C1
    req_valid = 1'b0;
    check("rstmid_rd_c1", 64'(f_rd), 64'd1);
    step();                               // C2
    step();                               // C3
    rst_n = 1'b0;
    #1;
    check("rstmid_rd_req", 64'(f_rd), 64'd0);
    check("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rstmid_rsp_err", 64'(rsp_err), 64'd0);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rstmid_ready", 64'(req_ready), 64'd1);
    repeat (12) step();
    do_write(16'h0700, 32'h7777_0007, 4'hC);

    repeat (3) step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
